// File: rtl/ex_operand_stage.sv
// Execute-stage operand register: captures the decoded instruction and resolves
// ALU operands with EX/MEM and MEM/WB forwarding.
module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic                      in_alu_src_a_pc,
    input  logic                      in_alu_src_b_imm,
    input  logic [OPCODE_LENGTH-1:0]  in_alu_op,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
    input  logic                      in_reg_write,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_alu_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_wb_data,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic                      out_valid,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_reg_write,
    output logic [DATA_WIDTH-1:0]     out_store_data,
    output logic [DATA_WIDTH-1:0]     out_pc
);

    // Unused opcode that the ALU maps to a zero result.
    localparam logic [OPCODE_LENGTH-1:0] BUBBLE_OP = {OPCODE_LENGTH{1'b1}};

    logic                      valid_q,      valid_d;
    logic                      reg_write_q,  reg_write_d;
    logic [OPCODE_LENGTH-1:0]  op_q,         op_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q,   rs1_addr_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_q,   rs2_addr_d;
    logic [DATA_WIDTH-1:0]     rs1_data_q,   rs1_data_d;
    logic [DATA_WIDTH-1:0]     rs2_data_q,   rs2_data_d;
    logic [DATA_WIDTH-1:0]     imm_q,        imm_d;
    logic [DATA_WIDTH-1:0]     pc_q,         pc_d;
    logic                      src_a_pc_q,   src_a_pc_d;
    logic                      src_b_imm_q,  src_b_imm_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;

    logic [DATA_WIDTH-1:0]     fwd_a_s;
    logic [DATA_WIDTH-1:0]     fwd_b_s;

    // EX/MEM beats MEM/WB; index 0 is hard-wired zero and never forwarded.
    function automatic logic [DATA_WIDTH-1:0] fwd_value(
        input logic [REG_ADDR_WIDTH-1:0] src_addr,
        input logic [DATA_WIDTH-1:0]     src_data,
        input logic                      em_we,
        input logic [REG_ADDR_WIDTH-1:0] em_rd,
        input logic [DATA_WIDTH-1:0]     em_data,
        input logic                      mw_we,
        input logic [REG_ADDR_WIDTH-1:0] mw_rd,
        input logic [DATA_WIDTH-1:0]     mw_data
    );
        logic [DATA_WIDTH-1:0] res;
        if (em_we && (em_rd != {REG_ADDR_WIDTH{1'b0}}) && (em_rd == src_addr)) begin
            res = em_data;
        end else if (mw_we && (mw_rd != {REG_ADDR_WIDTH{1'b0}}) && (mw_rd == src_addr)) begin
            res = mw_data;
        end else begin
            res = src_data;
        end
        return res;
    endfunction

    // Next-state selection: flush, then stall, then capture.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        op_d        = op_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        src_a_pc_d  = src_a_pc_q;
        src_b_imm_d = src_b_imm_q;
        rd_addr_d   = rd_addr_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            op_d        = BUBBLE_OP;
            rs1_addr_d  = {REG_ADDR_WIDTH{1'b0}};
            rs2_addr_d  = {REG_ADDR_WIDTH{1'b0}};
            rs1_data_d  = {DATA_WIDTH{1'b0}};
            rs2_data_d  = {DATA_WIDTH{1'b0}};
            imm_d       = {DATA_WIDTH{1'b0}};
            pc_d        = {DATA_WIDTH{1'b0}};
            src_a_pc_d  = 1'b0;
            src_b_imm_d = 1'b0;
            rd_addr_d   = {REG_ADDR_WIDTH{1'b0}};
        end else if (stall) begin
            valid_d     = valid_q;
            reg_write_d = reg_write_q;
        end else begin
            valid_d     = in_valid;
            reg_write_d = in_reg_write & in_valid;
            op_d        = in_alu_op;
            rs1_addr_d  = in_rs1_addr;
            rs2_addr_d  = in_rs2_addr;
            rs1_data_d  = in_rs1_data;
            rs2_data_d  = in_rs2_data;
            imm_d       = in_imm;
            pc_d        = in_pc;
            src_a_pc_d  = in_alu_src_a_pc;
            src_b_imm_d = in_alu_src_b_imm;
            rd_addr_d   = in_rd_addr;
        end
    end

    // Stage register; reset loads the bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            op_q        <= BUBBLE_OP;
            rs1_addr_q  <= {REG_ADDR_WIDTH{1'b0}};
            rs2_addr_q  <= {REG_ADDR_WIDTH{1'b0}};
            rs1_data_q  <= {DATA_WIDTH{1'b0}};
            rs2_data_q  <= {DATA_WIDTH{1'b0}};
            imm_q       <= {DATA_WIDTH{1'b0}};
            pc_q        <= {DATA_WIDTH{1'b0}};
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            rd_addr_q   <= {REG_ADDR_WIDTH{1'b0}};
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            op_q        <= op_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            src_a_pc_q  <= src_a_pc_d;
            src_b_imm_q <= src_b_imm_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    // Forwarding is evaluated every cycle so a stalled instruction sees fresh results.
    always_comb begin
        fwd_a_s = fwd_value(rs1_addr_q, rs1_data_q, exmem_reg_write, exmem_rd_addr,
                            exmem_alu_result, memwb_reg_write, memwb_rd_addr, memwb_wb_data);
        fwd_b_s = fwd_value(rs2_addr_q, rs2_data_q, exmem_reg_write, exmem_rd_addr,
                            exmem_alu_result, memwb_reg_write, memwb_rd_addr, memwb_wb_data);
    end

    // Operand muxing and output drive.
    always_comb begin
        if (src_a_pc_q) begin
            SrcA = pc_q;
        end else begin
            SrcA = fwd_a_s;
        end
        if (src_b_imm_q) begin
            SrcB = imm_q;
        end else begin
            SrcB = fwd_b_s;
        end
        out_store_data = fwd_b_s;
        Operation      = op_q;
        out_valid      = valid_q;
        out_reg_write  = reg_write_q;
        out_rd_addr    = rd_addr_q;
        out_pc         = pc_q;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, stall, flush;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        in_alu_src_a_pc, in_alu_src_b_imm, in_reg_write;
    logic [3:0]  in_alu_op;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd_addr, memwb_rd_addr;
    logic [31:0] exmem_alu_result, memwb_wb_data;
    logic [31:0] SrcA, SrcB, out_store_data, out_pc;
    logic [3:0]  Operation;
    logic        out_valid, out_reg_write;
    logic [4:0]  out_rd_addr;

    int tests_run = 0;
    int tests_failed = 0;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc),
        .in_alu_src_a_pc(in_alu_src_a_pc), .in_alu_src_b_imm(in_alu_src_b_imm),
        .in_alu_op(in_alu_op), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
        .exmem_alu_result(exmem_alu_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
        .memwb_wb_data(memwb_wb_data),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
        .out_store_data(out_store_data), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; in_rd_addr = 5'd0;
        in_rs1_data = 32'd0; in_rs2_data = 32'd0; in_imm = 32'd0; in_pc = 32'd0;
        in_alu_src_a_pc = 1'b0; in_alu_src_b_imm = 1'b0; in_reg_write = 1'b0;
        in_alu_op = 4'd0;
        exmem_reg_write = 1'b0; exmem_rd_addr = 5'd0; exmem_alu_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd_addr = 5'd0; memwb_wb_data = 32'd0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick(); tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        tests_run++; if (out_reg_write !== 1'b0) begin tests_failed++; $display("FAIL reset_regwr got %0b exp 0", out_reg_write); end
        tests_run++; if (Operation !== 4'b1111) begin tests_failed++; $display("FAIL reset_op got %h exp f", Operation); end
        tests_run++; if (SrcA !== 32'd0 || SrcB !== 32'd0 || out_store_data !== 32'd0 || out_pc !== 32'd0 || out_rd_addr !== 5'd0)
            begin tests_failed++; $display("FAIL reset_fields got A=%h B=%h st=%h pc=%h rd=%h exp all 0", SrcA, SrcB, out_store_data, out_pc, out_rd_addr); end
        reset = 1'b0;
        tick();
        tests_run++; if (Operation !== 4'b0000 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resume got op=%h v=%0b exp op=0 v=0", Operation, out_valid); end
    endtask

    task automatic test_load();
        drive_idle();
        in_valid = 1'b1; in_alu_op = 4'b0010; in_rs1_addr = 5'd1; in_rs1_data = 32'd5;
        in_rs2_addr = 5'd2; in_rs2_data = 32'd9; in_imm = 32'd7; in_alu_src_b_imm = 1'b1;
        in_pc = 32'h100; in_rd_addr = 5'd4; in_reg_write = 1'b1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL load_latency got v=%0b exp 0 before edge", out_valid); end
        tick();
        tests_run++; if (SrcA !== 32'd5) begin tests_failed++; $display("FAIL load_srca got %h exp 5", SrcA); end
        tests_run++; if (SrcB !== 32'd7) begin tests_failed++; $display("FAIL load_srcb got %h exp 7", SrcB); end
        tests_run++; if (Operation !== 4'b0010 || out_valid !== 1'b1 || out_reg_write !== 1'b1)
            begin tests_failed++; $display("FAIL load_ctrl got op=%h v=%0b rw=%0b exp 2 1 1", Operation, out_valid, out_reg_write); end
        tests_run++; if (out_store_data !== 32'd9 || out_pc !== 32'h100 || out_rd_addr !== 5'd4)
            begin tests_failed++; $display("FAIL load_fields got st=%h pc=%h rd=%h exp 9 100 4", out_store_data, out_pc, out_rd_addr); end
        // PC as SrcA, register rs2 as SrcB
        in_alu_src_a_pc = 1'b1; in_alu_src_b_imm = 1'b0; in_pc = 32'hDEAD_BEEF;
        tick();
        tests_run++; if (SrcA !== 32'hDEAD_BEEF || SrcB !== 32'd9)
            begin tests_failed++; $display("FAIL load_pcsel got A=%h B=%h exp deadbeef 9", SrcA, SrcB); end
    endtask

    task automatic test_exmem_fwd();
        drive_idle();
        in_valid = 1'b1; in_rs1_addr = 5'd3; in_rs1_data = 32'h11;
        in_rs2_addr = 5'd3; in_rs2_data = 32'h22; in_imm = 32'h77; in_alu_src_b_imm = 1'b1;
        tick();
        exmem_reg_write = 1'b1; exmem_rd_addr = 5'd3; exmem_alu_result = 32'hAA;
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd3; memwb_wb_data = 32'hBB;
        #1;
        tests_run++; if (SrcA !== 32'hAA) begin tests_failed++; $display("FAIL fwd_exmem got %h exp aa", SrcA); end
        tests_run++; if (out_store_data !== 32'hAA || SrcB !== 32'h77)
            begin tests_failed++; $display("FAIL fwd_store got st=%h B=%h exp aa 77", out_store_data, SrcB); end
        exmem_reg_write = 1'b0; #1;
        tests_run++; if (SrcA !== 32'hBB) begin tests_failed++; $display("FAIL fwd_memwb got %h exp bb", SrcA); end
        exmem_reg_write = 1'b1; exmem_rd_addr = 5'd4; #1;
        tests_run++; if (SrcA !== 32'hBB) begin tests_failed++; $display("FAIL fwd_exmem_mismatch got %h exp bb", SrcA); end
        memwb_reg_write = 1'b0; #1;
        tests_run++; if (SrcA !== 32'h11 || out_store_data !== 32'h22)
            begin tests_failed++; $display("FAIL fwd_none got A=%h st=%h exp 11 22", SrcA, out_store_data); end
    endtask

    task automatic test_x0_guard();
        drive_idle();
        in_valid = 1'b1; in_rs2_addr = 5'd0; in_rs2_data = 32'd0; in_rs1_addr = 5'd0; in_rs1_data = 32'h33;
        tick();
        exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_alu_result = 32'h55;
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd0; memwb_wb_data = 32'h66;
        #1;
        tests_run++; if (SrcB !== 32'd0 || out_store_data !== 32'd0)
            begin tests_failed++; $display("FAIL x0_rs2 got B=%h st=%h exp 0 0", SrcB, out_store_data); end
        tests_run++; if (SrcA !== 32'h33) begin tests_failed++; $display("FAIL x0_rs1 got %h exp 33", SrcA); end
    endtask

    task automatic test_stall_flush();
        drive_idle();
        in_valid = 1'b1; in_alu_op = 4'b0110; in_rs1_addr = 5'd7; in_rs1_data = 32'h1234;
        in_pc = 32'h40; in_rd_addr = 5'd9; in_reg_write = 1'b1;
        tick();
        stall = 1'b1;
        in_alu_op = 4'b0001; in_rs1_data = 32'h9999; in_pc = 32'h80; in_rd_addr = 5'd2; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (Operation !== 4'b0110 || SrcA !== 32'h1234 || out_pc !== 32'h40 || out_rd_addr !== 5'd9 || out_valid !== 1'b1 || out_reg_write !== 1'b1)
                begin tests_failed++; $display("FAIL stall_hold%0d got op=%h A=%h pc=%h rd=%h v=%0b rw=%0b exp 6 1234 40 9 1 1", i, Operation, SrcA, out_pc, out_rd_addr, out_valid, out_reg_write); end
        end
        memwb_reg_write = 1'b1; memwb_rd_addr = 5'd7; memwb_wb_data = 32'hCAFE; #1;
        tests_run++; if (SrcA !== 32'hCAFE) begin tests_failed++; $display("FAIL stall_fwd got %h exp cafe", SrcA); end
        flush = 1'b1;
        tick();
        tests_run++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || Operation !== 4'b1111 || out_pc !== 32'd0 || out_rd_addr !== 5'd0)
            begin tests_failed++; $display("FAIL flush got v=%0b rw=%0b op=%h pc=%h rd=%h exp 0 0 f 0 0", out_valid, out_reg_write, Operation, out_pc, out_rd_addr); end
    endtask

    task automatic test_async_reset();
        drive_idle();
        in_valid = 1'b1; in_alu_op = 4'b0011; in_pc = 32'h200; in_reg_write = 1'b1;
        tick();
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_pre got v=%0b exp 1", out_valid); end
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b0 || Operation !== 4'b1111 || out_reg_write !== 1'b0 || out_pc !== 32'd0)
            begin tests_failed++; $display("FAIL areset got v=%0b op=%h rw=%0b pc=%h exp 0 f 0 0", out_valid, Operation, out_reg_write, out_pc); end
        #1 reset = 1'b0;
        stall = 1'b0;
        tick();
        tests_run++; if (out_valid !== 1'b1 || Operation !== 4'b0011 || out_pc !== 32'h200)
            begin tests_failed++; $display("FAIL areset_resume got v=%0b op=%h pc=%h exp 1 3 200", out_valid, Operation, out_pc); end
    endtask

    task automatic test_invalid_capture();
        drive_idle();
        in_valid = 1'b0; in_reg_write = 1'b1; in_alu_op = 4'b0101; in_rd_addr = 5'd6;
        tick();
        tests_run++; if (out_reg_write !== 1'b0 || out_valid !== 1'b0)
            begin tests_failed++; $display("FAIL invalid got rw=%0b v=%0b exp 0 0", out_reg_write, out_valid); end
        tests_run++; if (Operation !== 4'b0101 || out_rd_addr !== 5'd6)
            begin tests_failed++; $display("FAIL invalid_fields got op=%h rd=%h exp 5 6", Operation, out_rd_addr); end
    endtask

    task automatic test_back_to_back();
        drive_idle();
        in_valid = 1'b1; in_alu_op = 4'b0000; in_rs1_data = 32'h1; in_reg_write = 1'b1;
        tick();
        in_alu_op = 4'b0111; in_rs1_data = 32'h2;
        tick();
        tests_run++; if (Operation !== 4'b0111 || SrcA !== 32'h2 || out_valid !== 1'b1)
            begin tests_failed++; $display("FAIL b2b got op=%h A=%h v=%0b exp 7 2 1", Operation, SrcA, out_valid); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_exmem_fwd();
        test_x0_guard();
        test_stall_flush();
        test_async_reset();
        test_invalid_capture();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 The block SHALL have the following parameters, one per line, as name, default and meaning:
- DATA_WIDTH, 32, datapath width.
- OPCODE_LENGTH, 4, ALU operation code width.
- REG_ADDR_WIDTH, 5, register index width.

REQ-002 The block SHALL have the following ports, one per line, as name, direction, width and meaning:
- clk  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  decode stage presents an instruction.
- stall  in  1  hold all registered state.
- flush  in  1  replace the stage contents with a bubble.
- in_rs1_addr, in_rs2_addr  in  REG_ADDR_WIDTH  source register indices.
- in_rs1_data, in_rs2_data  in  DATA_WIDTH  register-file read data.
- in_imm, in_pc  in  DATA_WIDTH  immediate value and instruction PC.
- in_alu_src_a_pc  in  1  1 selects the PC as SrcA.
- in_alu_src_b_imm  in  1  1 selects the immediate as SrcB.
- in_alu_op  in  OPCODE_LENGTH  ALU operation code.
- in_rd_addr  in  REG_ADDR_WIDTH  destination register index.
- in_reg_write  in  1  instruction writes rd.
- exmem_reg_write  in  1  write-back enable from EX/MEM.
- exmem_rd_addr  in  REG_ADDR_WIDTH  destination index from EX/MEM.
- exmem_alu_result  in  DATA_WIDTH  result from EX/MEM.
- memwb_reg_write  in  1  write-back enable from MEM/WB.
- memwb_rd_addr  in  REG_ADDR_WIDTH  destination index from MEM/WB.
- memwb_wb_data  in  DATA_WIDTH  write-back data from MEM/WB.
- SrcA, SrcB  out  DATA_WIDTH  ALU operands.
- Operation  out  OPCODE_LENGTH  ALU operation code.
- out_valid  out  1  stage holds a live instruction.
- out_rd_addr  out  REG_ADDR_WIDTH  registered destination index.
- out_reg_write  out  1  registered write enable.
- out_store_data  out  DATA_WIDTH  forwarded rs2 value, used by stores.
- out_pc  out  DATA_WIDTH  registered PC.

REQ-003 The block SHALL use one clock (clk) and an asynchronous, active-high reset (reset); there SHALL be no other clock or reset.

Function
REQ-004 The block SHALL register all in_* fields on the rising edge of clk, giving one cycle of latency from decode to the ALU operands.

REQ-005 Update priority on each edge SHALL be flush > stall > load.
- flush=1: out_valid←0, out_reg_write←0, Operation←4'b1111, and every other registered field ←0.
- stall=1 (with flush=0): all registered fields hold their values.
- otherwise: capture all in_* fields; out_valid←in_valid; out_reg_write←in_reg_write & in_valid.

REQ-006 A bubble SHALL drive Operation=4'b1111, which is an unused code the ALU maps to a result of 0.

REQ-007 Forwarded A SHALL be selected combinationally from the registered rs1 index, in this order:
- exmem_alu_result, if exmem_reg_write=1, exmem_rd_addr≠0 and exmem_rd_addr equals the registered rs1 index;
- else memwb_wb_data, if memwb_reg_write=1, memwb_rd_addr≠0 and memwb_rd_addr equals the registered rs1 index;
- else the registered rs1 data.

REQ-008 Forwarded B SHALL use the same rule as REQ-007 applied to the registered rs2 index and rs2 data.

REQ-009 When both EX/MEM and MEM/WB match the same source index, EX/MEM SHALL win.

REQ-010 Register x0 (index 0) SHALL never be forwarded, so a source index of 0 always yields the registered data.

REQ-011 The operand outputs SHALL be driven as follows:
- SrcA = registered in_alu_src_a_pc ? registered PC : forwarded A.
- SrcB = registered in_alu_src_b_imm ? registered immediate : forwarded B.
- out_store_data = forwarded B, regardless of in_alu_src_b_imm.

REQ-012 Forwarding SHALL be evaluated every cycle, including while stalled, so a held instruction picks up newly arriving results.

REQ-013 Forwarding SHALL stay active when out_valid=0; the operand values are then don't-care to downstream logic.

REQ-014 All data SHALL pass through without modification, with no arithmetic, sign extension or width change.

Reset
REQ-015 While reset=1, and immediately on its assertion (asynchronous), the block SHALL drive:
- out_valid=0 and out_reg_write=0;
- Operation=4'b1111;
- every other registered field equal to 0.

REQ-016 Reset asserted mid-stall or mid-flush SHALL override both.

REQ-017 On the first edge after reset deasserts, the block SHALL resume normal capture per REQ-005.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Load: in_valid=1, in_alu_op=4'b0010, rs1_data=5, imm=7, src_b_imm=1 -> next cycle SrcA=5, SrcB=7, Operation=4'b0010, out_valid=1.
- EX/MEM forwarding: registered rs1=3, exmem_reg_write=1, exmem_rd=3, exmem_alu_result=0xAA, memwb_rd=3, memwb_wb_data=0xBB -> SrcA=0xAA.
- x0 guard: registered rs2=0, exmem_reg_write=1, exmem_rd=0, exmem_alu_result=0x55, registered rs2_data=0 -> SrcB=0 and out_store_data=0.
- Stall and flush: stall=1 for 3 cycles -> all outputs held; then flush=1 and stall=1 together -> next cycle out_valid=0, out_reg_write=0, Operation=4'b1111.
- Asynchronous reset: reset pulse between clock edges while out_valid=1 -> out_valid=0 and Operation=4'b1111 before the next edge.
- Invalid capture: in_valid=0, in_reg_write=1 -> out_reg_write=0 and out_valid=0.
